// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download router.
// Contents: FSM state enum, SDRAM byte-lane encodings, bus widths and a
// byte-duplication helper used for single-lane writes.
package rom_dl_pkg;

  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned DS_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  localparam logic [DS_W-1:0] DS_LO   = 2'b01;
  localparam logic [DS_W-1:0] DS_HI   = 2'b10;
  localparam logic [DS_W-1:0] DS_WORD = 2'b11;

  // Single-lane writes place the byte on both halves so either lane sees it.
  function automatic logic [WORD_W-1:0] dup_byte(input logic [BYTE_W-1:0] b);
    return {b, b};
  endfunction

endpackage

// File: rtl/rom_dl_router_if.sv
// Bus bundle between data_io / SDRAM write ports and the ROM download router.
// ioctl_* : byte stream from data_io (downl, index, wr, addr, dout) and the
//           ioctl_wait stall back to it.
// port_*  : NUM_PORTS toggle req/ack pairs plus the shared word address,
//           byte-lane enables, write data and write enable.
// Modports: slave = router side, master = data_io / SDRAM side.
interface rom_dl_router_if
  import rom_dl_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 23
);

  logic                    ioctl_downl;
  logic [BYTE_W-1:0]       ioctl_index;
  logic                    ioctl_wr;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [BYTE_W-1:0]       ioctl_dout;
  logic                    ioctl_wait;

  logic [NUM_PORTS-1:0]    port_req;
  logic [NUM_PORTS-1:0]    port_ack;
  logic [ADDR_W-1:0]       port_a;
  logic [DS_W-1:0]         port_ds;
  logic [WORD_W-1:0]       port_d;
  logic                    port_we;

  modport slave (
    input  ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port_ack,
    output ioctl_wait, port_req, port_a, port_ds, port_d, port_we
  );

  modport master (
    output ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, port_ack,
    input  ioctl_wait, port_req, port_a, port_ds, port_d, port_we
  );

endinterface

// File: rtl/rst_hold_ctr.sv
// Reset hold counter: reloads to RESET_CYCLES while any reset cause is
// present, otherwise counts down to zero. hold is registered (count != 0).
// Ports: clk, rst_n (async active-low), reload (any reset cause active),
//        hold (core reset, active-high).
module rst_hold_ctr #(
  parameter int unsigned RESET_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic hold
);

  localparam int unsigned CNT_W = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;
  logic             hold_q, hold_d;

  // Next count and hold level.
  always_comb begin
    count_d = count_q;
    hold_d  = (count_q != '0);
    if (reload) begin
      count_d = CNT_INIT;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_INIT;
      hold_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  assign hold = hold_q;

endmodule

// File: rtl/rom_dl_router.sv
// ROM download controller: packs data_io bytes into 16-bit words, writes each
// word to NUM_PORTS SDRAM ports via toggle req/ack, stalls data_io while a
// write is outstanding and drives the core reset and rom_loaded flag.
// Ports: clk_sys, reset_n (async active-low), bus (ioctl byte stream and
//        SDRAM write ports), rst_req (external reset request),
//        game_reset (core reset, active-high), rom_loaded (sticky).
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned ADDR_W       = 23,
  parameter logic [7:0]  ROM_INDEX    = 8'h00,
  parameter int unsigned RESET_CYCLES = 65535
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  rom_dl_router_if.slave bus,
  input  logic           rst_req,
  output logic           game_reset,
  output logic           rom_loaded
);

  state_e                  state_q, state_d;
  logic                    wr_last_q, wr_last_d;
  logic                    dl_last_q, dl_last_d;
  logic                    end_pend_q, end_pend_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    have_lo_q, have_lo_d;
  logic [BYTE_W-1:0]       lo_data_q, lo_data_d;
  logic [ADDR_W-1:0]       lo_addr_q, lo_addr_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [BYTE_W-1:0]       skid_data_q, skid_data_d;
  logic [IOCTL_ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [NUM_PORTS-1:0]    port_req_q, port_req_d;
  logic [ADDR_W-1:0]       port_a_q, port_a_d;
  logic [DS_W-1:0]         port_ds_q, port_ds_d;
  logic [WORD_W-1:0]       port_d_q, port_d_d;
  logic                    port_we_q, port_we_d;
  logic                    ioctl_wait_q, ioctl_wait_d;
  logic                    rom_loaded_q, rom_loaded_d;

  logic                    acc;
  logic                    dl_fall;
  logic                    pending;
  logic                    cur_valid;
  logic [BYTE_W-1:0]       cur_data;
  logic [IOCTL_ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0]       cur_word;
  logic                    addr_hi_unused;

  // Byte acceptance, download end and ack tracking.
  always_comb begin
    acc     = bus.ioctl_wr & ~wr_last_q & bus.ioctl_downl & (bus.ioctl_index == ROM_INDEX);
    dl_fall = dl_last_q & ~bus.ioctl_downl;
    pending = |(port_req_q ^ bus.port_ack);
  end

  // A byte parked in the skid register is older than a fresh strobe, so it goes first.
  always_comb begin
    cur_valid = skid_valid_q | acc;
    cur_data  = skid_valid_q ? skid_data_q : bus.ioctl_dout;
    cur_addr  = skid_valid_q ? skid_addr_q : bus.ioctl_addr;
    cur_word  = cur_addr[ADDR_W:1];
  end

  if (ADDR_W + 1 < IOCTL_ADDR_W) begin : g_addr_hi
    assign addr_hi_unused = ^cur_addr[IOCTL_ADDR_W-1:ADDR_W+1];
  end else begin : g_addr_full
    assign addr_hi_unused = 1'b0;
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    wr_last_d    = bus.ioctl_wr;
    dl_last_d    = bus.ioctl_downl;
    end_pend_d   = end_pend_q | dl_fall;
    flush_pend_d = flush_pend_q;
    have_lo_d    = have_lo_q;
    lo_data_d    = lo_data_q;
    lo_addr_d    = lo_addr_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;
    port_req_d   = port_req_q;
    port_a_d     = port_a_q;
    port_ds_d    = port_ds_q;
    port_d_d     = port_d_q;
    rom_loaded_d = rom_loaded_q;

    // Skid register: refilled only when empty or being drained this cycle.
    if (state_q == ST_IDLE) begin
      if (skid_valid_q) begin
        skid_valid_d = acc;
        if (acc) begin
          skid_data_d = bus.ioctl_dout;
          skid_addr_d = bus.ioctl_addr;
        end
      end
    end else if (acc && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = bus.ioctl_dout;
      skid_addr_d  = bus.ioctl_addr;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cur_valid) begin
          if (!cur_addr[0]) begin
            // A new even byte evicts any unpaired lo byte as a lo-lane write.
            if (have_lo_q) begin
              port_a_d  = lo_addr_q;
              port_ds_d = DS_LO;
              port_d_d  = dup_byte(lo_data_q);
              state_d   = ST_ISSUE;
            end
            lo_data_d = cur_data;
            lo_addr_d = cur_word;
            have_lo_d = 1'b1;
          end else if (have_lo_q && (lo_addr_q == cur_word)) begin
            port_a_d  = cur_word;
            port_ds_d = DS_WORD;
            port_d_d  = {cur_data, lo_data_q};
            have_lo_d = 1'b0;
            state_d   = ST_ISSUE;
          end else begin
            port_a_d  = cur_word;
            port_ds_d = DS_HI;
            port_d_d  = dup_byte(cur_data);
            state_d   = ST_ISSUE;
          end
        end else if (end_pend_q || dl_fall) begin
          end_pend_d = 1'b0;
          if (have_lo_q) begin
            state_d = ST_FLUSH;
          end else begin
            rom_loaded_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        port_a_d     = lo_addr_q;
        port_ds_d    = DS_LO;
        port_d_d     = dup_byte(lo_data_q);
        have_lo_d    = 1'b0;
        flush_pend_d = 1'b1;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        port_req_d = ~port_req_q;
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!pending) begin
          state_d = ST_IDLE;
          if (flush_pend_q) begin
            flush_pend_d = 1'b0;
            rom_loaded_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ioctl_wait_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK);
    port_we_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_last_q    <= 1'b0;
      dl_last_q    <= 1'b0;
      end_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      have_lo_q    <= 1'b0;
      lo_data_q    <= '0;
      lo_addr_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_addr_q  <= '0;
      port_req_q   <= '0;
      port_a_q     <= '0;
      port_ds_q    <= '0;
      port_d_q     <= '0;
      port_we_q    <= 1'b0;
      ioctl_wait_q <= 1'b0;
      rom_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_last_q    <= wr_last_d;
      dl_last_q    <= dl_last_d;
      end_pend_q   <= end_pend_d;
      flush_pend_q <= flush_pend_d;
      have_lo_q    <= have_lo_d;
      lo_data_q    <= lo_data_d;
      lo_addr_q    <= lo_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
      port_req_q   <= port_req_d;
      port_a_q     <= port_a_d;
      port_ds_q    <= port_ds_d;
      port_d_q     <= port_d_d;
      port_we_q    <= port_we_d;
      ioctl_wait_q <= ioctl_wait_d;
      rom_loaded_q <= rom_loaded_d;
    end
  end

  // Core reset hold: any reset cause, an active download or no ROM yet.
  rst_hold_ctr #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_rst_hold (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .reload (rst_req | bus.ioctl_downl | ~rom_loaded_q),
    .hold   (game_reset)
  );

  assign bus.port_req   = port_req_q;
  assign bus.port_a     = port_a_q;
  assign bus.port_ds    = port_ds_q;
  assign bus.port_d     = port_d_q;
  assign bus.port_we    = port_we_q;
  assign bus.ioctl_wait = ioctl_wait_q;
  assign rom_loaded     = rom_loaded_q;

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Generalised ROM download controller for MiST arcade cores.
- Replaces the ad-hoc top-level logic that toggles every SDRAM port request on each ioctl byte and holds the game in reset.
- Packs ioctl bytes into 16-bit words and writes each word to NUM_PORTS SDRAM ports through a req/ack toggle handshake.
- Back-pressures data_io with ioctl_wait and generates the core reset and rom_loaded.

Parameters:
- NUM_PORTS, 2, number of SDRAM write ports written in parallel (1..4).
- ADDR_W, 23, SDRAM word-address width; port_a = ioctl_addr[ADDR_W:1].
- ROM_INDEX, 8'h00, ioctl_index value accepted; other indices are ignored.
- RESET_CYCLES, 65535, game_reset hold length after the last reset cause clears.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_downl  in  1  download active.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  byte strobe; level, may last several cycles.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to data_io.
- port_req  out  NUM_PORTS  toggle request per port.
- port_ack  in  NUM_PORTS  toggle acknowledge per port.
- port_a  out  ADDR_W  word address, shared by all ports.
- port_ds  out  2  byte lane enables {hi, lo}.
- port_d  out  16  write data.
- port_we  out  1  write enable; follows an accepted download.
- rst_req  in  1  external reset request (menu reset or button).
- game_reset  out  1  core reset, active-high.
- rom_loaded  out  1  sticky; set at the first complete download.

Behaviour:
- Reset values: port_req=0, port_a=0, port_ds=0, port_d=0, port_we=0, ioctl_wait=0, rom_loaded=0, game_reset=1. The internal hold counter is loaded with RESET_CYCLES.
- Strobe detection: wr_last is registered. A byte is accepted on the cycle where ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index==ROM_INDEX). Exactly one acceptance per strobe, however long ioctl_wr stays high.
- FSM states: IDLE, ISSUE, WAIT_ACK, FLUSH.
- IDLE, even-address byte: latch lo byte and its word address, set have_lo.
- IDLE, odd-address byte, have_lo set, same word address: build word {byte, lo}, ds=2'b11, go to ISSUE.
- IDLE, odd-address byte otherwise: ds=2'b10, data {byte, byte}, go to ISSUE.
- IDLE, even-address byte with have_lo already set: first issue the stale lo byte with ds=2'b01, then latch the new byte.
- ISSUE (one cycle): drive port_a/ds/d and toggle every port_req bit; go to WAIT_ACK.
- WAIT_ACK: port i is pending while port_req[i]^port_ack[i]. Leave for IDLE only when no port is pending. Outputs stay stable throughout.
- ioctl_wait=1 in ISSUE and WAIT_ACK. A byte accepted while busy is held in a one-entry skid register and processed on return to IDLE. A second byte arriving while the skid register is full is dropped. This is a data_io protocol violation and is not otherwise flagged.
- Falling edge of ioctl_downl with have_lo set: enter FLUSH and issue ds=2'b01. rom_loaded is set after the flush ack; with no pending byte it is set on the falling edge itself.
- Reset hold: the counter reloads to RESET_CYCLES while any of rst_req, ioctl_downl or ~rom_loaded is true. Otherwise it decrements to 0. game_reset is registered: game_reset <= (count != 0).
- reset_n asserted mid-handshake: all state is cleared, including port_req. The SDRAM controller is reset from the same source, so toggle parity stays consistent.

Decomposition:
- Shared package rom_dl_pkg holds the FSM state enum, DS_LO=2'b01, DS_HI=2'b10 and DS_WORD=2'b11.
- One sub-module, rst_hold_ctr (parameter RESET_CYCLES), holds the reload/decrement counter and is reusable by other cores.
- Byte packing and the FSM stay in rom_dl_router.

Test Plan:
- Bytes 0x11@0, 0x22@1, index 0: one write, a=0, ds=11, d=0x2211, all port_req toggle once. Acking port 0 only keeps ioctl_wait=1 until port 1 acks.
- Byte 0x33@5 alone: ds=10, a=2, d=0x3333. Byte 0x44@6 then download end: flush ds=01, a=3, d=0x4444, then rom_loaded=1.
- ioctl_wr held high for 10 cycles: exactly one byte accepted. Index 1 during download: no port_req change.
- Acks delayed 20 cycles while data_io sends one more byte: byte captured in the skid register, written after the prior ack, data intact.
- rom_loaded=1, pulse rst_req: game_reset stays 1 for RESET_CYCLES+1 cycles after rst_req falls (use RESET_CYCLES=16 in bench). Before the first download completes, game_reset is constantly 1.
- reset_n low in WAIT_ACK: all outputs return to reset values within the same cycle (asynchronous). The next download's first write toggles port_req from 0.
